// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: FUNC3 opcodes and FSM state encoding.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift {rem,quo} left by one and conditionally subtract the divisor.
module muldiv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // rem < divisor on entry, so shifted < 2*divisor and the borrow lands in trial[XLEN]
    assign shifted = {rem_in, quo_in[XLEN-1]};
    assign trial   = shifted - {1'b0, divisor};
    assign rem_out = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_out = {quo_in[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage.
// Define MULDIV_FAST_MUL_EN for a single-cycle '*' multiply; otherwise multiply is iterative shift-add.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FLUSH,
    input  logic            HOLD,
    input  logic            START,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OPERAND_A,
    input  logic [XLEN-1:0] OPERAND_B,
    output logic            BUSY,
    output logic            RESULT_VALID,
    output logic [XLEN-1:0] RESULT
);

    localparam int CW = $clog2(XLEN);

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3_r;
    logic            neg_q_r, neg_r_r;
    logic [XLEN-1:0] hi_r, lo_r, opb_r;
    logic [XLEN-1:0] result_r, result_next;
    logic            valid_r;

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] mul_sel(input logic [2*XLEN-1:0] prod, input logic [2:0] f3);
        return (f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] div_sel(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                                input logic [2:0] f3, input logic nq, input logic nr);
        return f3[1] ? cond_neg(r, nr) : cond_neg(q, nq);
    endfunction

    // Operand decode: signed ops are reduced to magnitudes plus sign flags
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_res;

    assign a_sgn    = (FUNC3 == F3_MULH) | (FUNC3 == F3_MULHSU) | (FUNC3 == F3_DIV) | (FUNC3 == F3_REM);
    assign b_sgn    = (FUNC3 == F3_MULH) | (FUNC3 == F3_DIV) | (FUNC3 == F3_REM);
    assign a_neg    = a_sgn & OPERAND_A[XLEN-1];
    assign b_neg    = b_sgn & OPERAND_B[XLEN-1];
    assign a_mag    = a_neg ? -OPERAND_A : OPERAND_A;
    assign b_mag    = b_neg ? -OPERAND_B : OPERAND_B;
    assign div_zero = (OPERAND_B == '0);
    assign div_ovf  = FUNC3[2] & ~FUNC3[0] & (OPERAND_A == {1'b1, {(XLEN-1){1'b0}}}) & (OPERAND_B == '1);

    // Zero divisor: Q=all-ones, R=dividend. Overflow: Q=dividend (-2^31), R=0.
    always_comb begin
        special_res = '0;
        if (div_zero) special_res = FUNC3[1] ? OPERAND_A : '1;
        else          special_res = FUNC3[1] ? '0 : OPERAND_A;
    end

    logic [XLEN-1:0] step_rem, step_quo;

    muldiv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (hi_r),
        .quo_in  (lo_r),
        .divisor (opb_r),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Shift-add multiply: add multiplicand into the high half when the low bit is set, then shift right
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi, mul_lo;

    assign mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : '0);
    assign mul_hi  = mul_sum[XLEN:1];
    assign mul_lo  = {mul_sum[0], lo_r[XLEN-1:1]};

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    logic last;
    assign last = (cnt == CW'(XLEN-1));

    always_comb begin
        state_next  = state;
        result_next = result_r;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    if (FUNC3[2]) begin
                        if (div_zero | div_ovf) begin
                            state_next  = ST_DONE;
                            result_next = special_res;
                        end else begin
                            state_next = ST_DIV;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        state_next  = ST_DONE;
                        result_next = mul_sel(cond_neg_wide(fast_prod, a_neg ^ b_neg), FUNC3);
`else
                        state_next  = ST_MUL;
`endif
                    end
                end
            end
            ST_MUL: begin
                if (last) begin
                    state_next  = ST_DONE;
                    result_next = mul_sel(cond_neg_wide({mul_hi, mul_lo}, neg_q_r), f3_r);
                end
            end
            ST_DIV: begin
                if (last) begin
                    state_next  = ST_DONE;
                    result_next = div_sel(step_quo, step_rem, f3_r, neg_q_r, neg_r_r);
                end
            end
            ST_DONE: begin
                if (!HOLD) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (FLUSH) begin
            state_next  = ST_IDLE;
            result_next = result_r;
        end
    end

    assign BUSY = ~RESET & (((state == ST_IDLE) & START) | (state == ST_MUL) | (state == ST_DIV));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            result_r <= '0;
            valid_r  <= 1'b0;
        end else begin
            state    <= state_next;
            result_r <= result_next;
            valid_r  <= (state_next == ST_DONE);
            if ((state == ST_MUL) || (state == ST_DIV)) cnt <= cnt + 1'b1;
            else                                        cnt <= '0;
        end
    end

    // Datapath registers carry no reset; they are always loaded on START before use
    always_ff @(posedge CLK) begin
        if ((state == ST_IDLE) && START) begin
            f3_r    <= FUNC3;
            neg_q_r <= a_neg ^ b_neg;
            neg_r_r <= a_neg;
            hi_r    <= '0;
            lo_r    <= a_mag;
            opb_r   <= b_mag;
        end else if (state == ST_MUL) begin
            hi_r <= mul_hi;
            lo_r <= mul_lo;
        end else if (state == ST_DIV) begin
            hi_r <= step_rem;
            lo_r <= step_quo;
        end
    end

    assign RESULT_VALID = valid_r;
    assign RESULT       = result_r;

endmodule
